// File: rtl/lcd_char_driver.sv
// HD44780-style 8-bit LCD write controller: runs the power-up init sequence, then
// refreshes a 2-line display from an external character buffer, one bus phase per tick.
module lcd_char_driver #(
  parameter int LINE_LEN = 16,
  parameter int CLR_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_clk1,
  input  logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [3:0] S_FSET  = 4'd0;
  localparam logic [3:0] S_DISP  = 4'd1;
  localparam logic [3:0] S_ENTRY = 4'd2;
  localparam logic [3:0] S_CLR   = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_L1A   = 4'd5;
  localparam logic [3:0] S_L1C   = 4'd6;
  localparam logic [3:0] S_L2A   = 4'd7;
  localparam logic [3:0] S_L2C   = 4'd8;

  localparam logic [3:0] LAST_COL  = 4'(LINE_LEN - 1);
  localparam logic [7:0] LAST_WAIT = 8'(CLR_WAIT - 1);

  logic [3:0] r_state;
  logic       r_phase;
  logic [3:0] r_col;
  logic [7:0] r_wait;
  logic [4:0] r_addr;
  logic       r_rs;
  logic       r_e;
  logic [7:0] r_data;
  logic       r_init_done;
  logic       r_frame_done;

  logic [7:0] w_byte;
  logic       w_rs;
  logic [3:0] w_next;
  logic       w_last_col;

  assign w_last_col = (r_col == LAST_COL);

  // Byte and register select to put on the bus for the current state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_byte = 8'h00;
    w_rs   = 1'b0;
    case (r_state)
      S_FSET:       w_byte = 8'h38;
      S_DISP:       w_byte = 8'h0C;
      S_ENTRY:      w_byte = 8'h06;
      S_CLR:        w_byte = 8'h01;
      S_L1A:        w_byte = 8'h80;
      S_L2A:        w_byte = 8'hC0;
      S_L1C, S_L2C: begin
        w_byte = char_data;
        w_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = S_FSET;
    case (r_state)
      S_FSET:  w_next = S_DISP;
      S_DISP:  w_next = S_ENTRY;
      S_ENTRY: w_next = S_CLR;
      S_CLR:   w_next = S_WAIT;
      S_WAIT:  w_next = S_L1A;
      S_L1A:   w_next = S_L1C;
      S_L1C:   w_next = w_last_col ? S_L2A : S_L1C;
      S_L2A:   w_next = S_L2C;
      S_L2C:   w_next = w_last_col ? S_L1A : S_L2C;
      default: w_next = S_FSET;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: frame_done defaults low every clk so a set lasts exactly one cycle.
    r_frame_done <= 1'b0;
    if (!rst) begin
      r_state     <= S_FSET;
      r_phase     <= 1'b0;
      r_col       <= 4'd0;
      r_wait      <= 8'd0;
      r_addr      <= 5'd0;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
    end else if (en_clk1) begin
      if (r_state == S_WAIT) begin
        if (r_wait == LAST_WAIT) begin
          r_wait      <= 8'd0;
          r_init_done <= 1'b1;
          r_state     <= S_L1A;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end else if (!r_phase) begin
        r_rs    <= w_rs;
        r_data  <= w_byte;
        r_e     <= 1'b1;
        r_phase <= 1'b1;
      end else begin
        r_e     <= 1'b0;
        r_phase <= 1'b0;
        r_state <= w_next;
        // The address for the next character is presented a full tick before it is sampled.
        case (r_state)
          S_L1A: r_addr <= 5'h00;
          S_L2A: r_addr <= 5'h10;
          S_L1C, S_L2C: begin
            if (w_last_col) begin
              r_col <= 4'd0;
              if (r_state == S_L2C) r_frame_done <= 1'b1;
            end else begin
              r_col  <= r_col + 4'd1;
              r_addr <= {(r_state == S_L2C), r_col + 4'd1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign char_addr  = r_addr;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = r_e;
  assign lcd_data   = r_data;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: expected bus writes are queued by the stimulus thread and
// popped by a monitor on every lcd_e strobe; a LINE_LEN=8 instance runs alongside.
module tb_lcd_char_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_clk1 = 1'b0;
  logic [7:0] char_data, char_data_b;
  logic [4:0] char_addr, char_addr_b;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic       lcd_rs_b, lcd_rw_b, lcd_e_b, init_done_b, frame_done_b;
  logic [7:0] lcd_data, lcd_data_b;

  logic [7:0] mem [0:31];
  logic [8:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int mode = 0;        // 0: tick every 4 clk, 1: tick every clk, 2: no ticks
  int exp_e_len = 4;   // expected lcd_e high time in clk, 0 = do not check

  always #5 clk = ~clk;

  assign char_data   = mem[char_addr];
  assign char_data_b = mem[char_addr_b];

  lcd_char_driver #(.LINE_LEN(16), .CLR_WAIT(3)) dut (
    .clk(clk), .rst(rst), .en_clk1(en_clk1), .char_data(char_data), .char_addr(char_addr),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  lcd_char_driver #(.LINE_LEN(8), .CLR_WAIT(3)) dut_b (
    .clk(clk), .rst(rst), .en_clk1(en_clk1), .char_data(char_data_b), .char_addr(char_addr_b),
    .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b), .lcd_e(lcd_e_b), .lcd_data(lcd_data_b),
    .init_done(init_done_b), .frame_done(frame_done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_init();
    sb_q.push_back(9'h038);
    sb_q.push_back(9'h00C);
    sb_q.push_back(9'h006);
    sb_q.push_back(9'h001);
  endtask

  task automatic push_frame();
    sb_q.push_back(9'h080);
    for (int c = 0; c < 16; c++) sb_q.push_back({1'b1, mem[c]});
    sb_q.push_back(9'h0C0);
    for (int c = 0; c < 16; c++) sb_q.push_back({1'b1, mem[16 + c]});
  endtask

  task automatic wait_frame(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!frame_done && cyc < budget);
    if (!frame_done) check("frame_done timeout", 32'd0, 32'd1);
  endtask

  // Tick generator; changes only on the falling edge.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      en_clk1 = (mode == 1) || (mode == 0 && cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  // Scoreboard monitor for the 16-column instance.
  initial begin
    logic       prev_e = 1'b0;
    logic       prev_fd = 1'b0;
    int         e_cnt = 0;
    int         wr_cnt = 0;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (lcd_e && !prev_e) begin
        e_cnt = 1;
        if (sb_q.size() == 0) begin
          check("unexpected write", {23'd0, lcd_rs, lcd_data}, 32'h1FF);
        end else begin
          exp = sb_q.pop_front();
          check("bus write", {23'd0, lcd_rs, lcd_data}, {23'd0, exp});
          check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
        end
        if (init_done) wr_cnt++;
      end else if (lcd_e) begin
        e_cnt++;
      end
      if (!lcd_e && prev_e && exp_e_len != 0) check("lcd_e width", e_cnt, exp_e_len);
      if (!init_done) wr_cnt = 0;
      if (frame_done) begin
        check("frame writes", wr_cnt, 34);
        wr_cnt = 0;
      end
      if (prev_fd) check("frame_done width", {31'd0, frame_done}, 32'd0);
      prev_e  = lcd_e;
      prev_fd = frame_done;
    end
  end

  // Monitor for the 8-column instance.
  initial begin
    logic prev_e = 1'b0;
    int   wr_cnt = 0;
    int   col_max = 0;
    forever begin
      @(negedge clk);
      if (lcd_e_b && !prev_e && init_done_b) begin
        wr_cnt++;
        if (lcd_rs_b && int'(char_addr_b[3:0]) > col_max) col_max = int'(char_addr_b[3:0]);
      end
      if (!init_done_b) wr_cnt = 0;
      if (frame_done_b) begin
        check("L8 frame writes", wr_cnt, 18);
        check("L8 max column", col_max, 7);
        wr_cnt  = 0;
        col_max = 0;
      end
      prev_e = lcd_e_b;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s0 = "HELLO WORLD     ";
    string s1 = "0123456789ABCDEF";
    int ticks;
    int cyc;
    int changes;
    logic [17:0] snap;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = s0[i];
      mem[16 + i] = s1[i];
    end

    // Reset for 5 clk with ticks running; they must be ignored.
    repeat (5) @(posedge clk);
    #1;
    check("reset outputs", {7'd0, char_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done}, 32'd0);
    check("reset outputs L8", {7'd0, char_addr_b, lcd_rs_b, lcd_rw_b, lcd_e_b, lcd_data_b, init_done_b, frame_done_b}, 32'd0);

    push_init();
    push_frame();
    push_frame();
    push_frame();
    @(negedge clk);
    rst = 1'b1;

    // Init: 4 writes of 2 ticks plus 3 wait ticks.
    ticks = 0;
    cyc = 0;
    do begin
      @(posedge clk);
      if (en_clk1) ticks++;
      #1;
      cyc++;
    end while (!init_done && cyc < 500);
    check("init_done tick count", ticks, 11);

    wait_frame(2000, cyc);
    wait_frame(2000, cyc);
    check("frame period clk", cyc, 272);

    // Stall the ticks for 1000 clk while a strobe is high.
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!lcd_e && cyc < 100);
    exp_e_len = 0;
    mode = 2;
    snap = {lcd_e, lcd_rs, lcd_data, char_addr, init_done, frame_done, 1'b0};
    changes = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if ({lcd_e, lcd_rs, lcd_data, char_addr, init_done, frame_done, 1'b0} !== snap) changes++;
    end
    check("stall outputs changed", changes, 0);
    check("stall lcd_e held", {31'd0, lcd_e}, 32'd1);
    mode = 0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (lcd_e && cyc < 100);
    @(negedge clk);
    #1;
    exp_e_len = 4;
    wait_frame(2000, cyc);
    check("scoreboard drained", sb_q.size(), 0);

    // Reset mid-character at line 2, column 7.
    push_frame();
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(char_addr == 5'h17 && lcd_e) && cyc < 2000);
    check("reached line 2 col 7", {27'd0, char_addr}, 32'h17);
    exp_e_len = 0;
    mode = 1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid-write reset outputs", {7'd0, char_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    push_init();
    push_frame();

    // Ticks every clk: init plus one frame in 79 clk.
    @(posedge clk);
    #1;
    exp_e_len = 1;
    cyc = 1;
    while (!frame_done && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    mode = 2;
    check("back-to-back frame clk", cyc, 79);
    check("init_done after frame", {31'd0, init_done}, 32'd1);
    repeat (5) @(posedge clk);
    check("scoreboard drained end", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
